// File: rtl/chrono_lap_timer_if.sv
// Button/display-side bundle of the lap chronometer: pulse commands in, live count and lap FIFO head out.
interface chrono_lap_timer_if #(
  parameter int DIGITS    = 4,
  parameter int LAP_DEPTH = 4
);
  localparam int CW = $clog2(LAP_DEPTH + 1);

  logic                start;
  logic                stop;
  logic                lap;
  logic                clear;
  logic                lap_rd;
  logic [4*DIGITS-1:0] time_bcd;
  logic                running;
  logic [4*DIGITS-1:0] lap_bcd;
  logic                lap_valid;
  logic [CW-1:0]       lap_count;
  logic                lap_full;
  logic                overflow;

  modport master (
    output start, stop, lap, clear, lap_rd,
    input  time_bcd, running, lap_bcd, lap_valid, lap_count, lap_full, overflow
  );

  modport slave (
    input  start, stop, lap, clear, lap_rd,
    output time_bcd, running, lap_bcd, lap_valid, lap_count, lap_full, overflow
  );
endinterface

// File: rtl/chrono_lap_timer.sv
// N-digit BCD chronometer with tick prescaler, lap capture FIFO and wrap/saturate overflow.
module chrono_lap_timer #(
  parameter int TICKS_PER_UNIT = 1000,
  parameter int DIGITS         = 4,
  parameter int LAP_DEPTH      = 4,
  parameter bit SATURATE       = 1'b0
) (
  input  logic               clock_i,
  input  logic               reset_i,
  chrono_lap_timer_if.slave  bus
);
  localparam int W   = 4 * DIGITS;
  localparam int PSW = $clog2(TICKS_PER_UNIT);
  localparam int PW  = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
  localparam int CW  = $clog2(LAP_DEPTH + 1);
  localparam logic [PSW-1:0] PS_LAST  = PSW'(TICKS_PER_UNIT - 1);
  localparam logic [PW-1:0]  PTR_LAST = PW'(LAP_DEPTH - 1);
  localparam logic [CW-1:0]  DEPTH_C  = CW'(LAP_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

  state_t          state_q, state_d;
  logic [PSW-1:0]  presc_q, presc_d;
  logic [W-1:0]    count_q, count_d, count_inc;
  logic            ovf_q, ovf_d;
  logic [W-1:0]    mem_q [LAP_DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    head_q, head_d;
  logic [DIGITS-1:0] nine;
  logic            in_run, tick, lap_ok, push, pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // A digit increments only when every lower digit is 9; all-9s rolls over to zero.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] dig;
      logic       cin;
      assign dig      = count_q[4*gi +: 4];
      assign nine[gi] = (dig == 4'd9);
      if (gi == 0) begin : g_lsd
        assign cin = 1'b1;
      end else begin : g_upper
        assign cin = &nine[gi-1:0];
      end
      assign count_inc[4*gi +: 4] = !cin ? dig : (nine[gi] ? 4'd0 : dig + 4'd1);
    end
  endgenerate

  assign in_run = (state_q == RUN);
  assign tick   = in_run && (presc_q == PS_LAST);
  // lap is the lowest-priority pulse: any concurrent start/stop/clear discards it.
  assign lap_ok = in_run && bus.lap && !bus.start && !bus.stop && !bus.clear;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (bus.stop && !bus.start) begin
      if (in_run) state_d = PAUSED;
    end else if (bus.start && !bus.stop) begin
      state_d = RUN;
    end
    if (in_run) presc_d = tick ? '0 : presc_q + PSW'(1);
    if (tick) begin
      if (&nine) ovf_d = 1'b1;
      count_d = (&nine && SATURATE) ? count_q : count_inc;
    end
    if (bus.clear) begin
      state_d = IDLE;
      presc_d = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end
  end

  always_comb begin
    pop      = bus.lap_rd && (cnt_q != '0) && !bus.clear;
    push     = lap_ok && ((cnt_q != DEPTH_C) || pop);
    rd_ptr_d = pop  ? ptr_next(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push ? ptr_next(wr_ptr_q) : wr_ptr_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    if (bus.clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end
    // The new head is the entry being written when nothing else remains ahead of it.
    if (cnt_d == '0) begin
      head_d = '0;
    end else if (push && (rd_ptr_d == wr_ptr_q)) begin
      head_d = count_q;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (push) mem_q[wr_ptr_q] <= count_q;
  end

  assign bus.time_bcd  = count_q;
  assign bus.running   = (state_q == RUN);
  assign bus.lap_bcd   = head_q;
  assign bus.lap_valid = (cnt_q != '0);
  assign bus.lap_count = cnt_q;
  assign bus.lap_full  = (cnt_q == DEPTH_C);
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_chrono_lap_timer.sv
// Drives a wrapping and a saturating chronometer with the same stimulus and checks both against an integer model.
module tb_chrono_lap_timer;
  localparam int T    = 4;
  localparam int D    = 2;
  localparam int LD   = 2;
  localparam int W    = 4 * D;
  localparam int MAXV = 99;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic start_s = 1'b0, stop_s = 1'b0, lap_s = 1'b0, clear_s = 1'b0, lap_rd_s = 1'b0;
  int   checks = 0;
  int   errors = 0;

  chrono_lap_timer_if #(.DIGITS(D), .LAP_DEPTH(LD)) bus0 ();
  chrono_lap_timer_if #(.DIGITS(D), .LAP_DEPTH(LD)) bus1 ();

  assign bus0.start = start_s;   assign bus1.start = start_s;
  assign bus0.stop = stop_s;     assign bus1.stop = stop_s;
  assign bus0.lap = lap_s;       assign bus1.lap = lap_s;
  assign bus0.clear = clear_s;   assign bus1.clear = clear_s;
  assign bus0.lap_rd = lap_rd_s; assign bus1.lap_rd = lap_rd_s;

  chrono_lap_timer #(.TICKS_PER_UNIT(T), .DIGITS(D), .LAP_DEPTH(LD), .SATURATE(1'b0))
    dut0 (.clock_i(clock), .reset_i(reset_n), .bus(bus0));
  chrono_lap_timer #(.TICKS_PER_UNIT(T), .DIGITS(D), .LAP_DEPTH(LD), .SATURATE(1'b1))
    dut1 (.clock_i(clock), .reset_i(reset_n), .bus(bus1));

  always #5 clock = ~clock;

  // Model state, index 0 = wrapping unit, index 1 = saturating unit.
  int m_state [2];
  int m_presc [2];
  int m_count [2];
  int m_n     [2];
  int m_lap   [2][LD];
  bit m_ovf   [2];
  bit m_valid = 1'b0;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    for (int m = 0; m < 2; m++) begin
      if (!reset_n) begin
        m_state[m] = S_IDLE; m_presc[m] = 0; m_count[m] = 0; m_n[m] = 0; m_ovf[m] = 1'b0;
      end else if (m_valid) begin
        if (clear_s) begin
          m_state[m] = S_IDLE; m_presc[m] = 0; m_count[m] = 0; m_n[m] = 0; m_ovf[m] = 1'b0;
        end else begin : step_model
          int snap, ns;
          bit lap_ok, pop, push;
          snap   = m_count[m];
          ns     = m_state[m];
          lap_ok = (m_state[m] == S_RUN) && lap_s && !start_s && !stop_s;
          if (stop_s && !start_s && m_state[m] == S_RUN) ns = S_PAUSED;
          if (start_s && !stop_s) ns = S_RUN;
          if (m_state[m] == S_RUN) begin
            m_presc[m]++;
            if (m_presc[m] == T) begin
              m_presc[m] = 0;
              if (m_count[m] == MAXV) begin
                m_ovf[m] = 1'b1;
                if (m == 0) m_count[m] = 0;
              end else begin
                m_count[m]++;
              end
            end
          end
          pop  = lap_rd_s && (m_n[m] > 0);
          push = lap_ok && ((m_n[m] < LD) || pop);
          if (pop) begin
            for (int k = 0; k < LD - 1; k++) m_lap[m][k] = m_lap[m][k+1];
            m_n[m]--;
          end
          if (push) begin
            m_lap[m][m_n[m]] = snap;
            m_n[m]++;
          end
          m_state[m] = ns;
        end
      end
    end
    if (!reset_n) m_valid = 1'b1;
  end

  task automatic compare_unit(input int m, input logic [W-1:0] t, input logic r,
                              input logic [W-1:0] lb, input logic lv, input logic [1:0] lc,
                              input logic lf, input logic ov);
    cmp($sformatf("sat%0d.time_bcd", m), t, to_bcd(m_count[m]));
    cmp($sformatf("sat%0d.running", m), r, m_state[m] == S_RUN);
    cmp($sformatf("sat%0d.lap_bcd", m), lb, (m_n[m] > 0) ? to_bcd(m_lap[m][0]) : '0);
    cmp($sformatf("sat%0d.lap_valid", m), lv, m_n[m] > 0);
    cmp($sformatf("sat%0d.lap_count", m), lc, m_n[m]);
    cmp($sformatf("sat%0d.lap_full", m), lf, m_n[m] == LD);
    cmp($sformatf("sat%0d.overflow", m), ov, m_ovf[m]);
  endtask

  always @(negedge clock) begin
    if (m_valid) begin
      compare_unit(0, bus0.time_bcd, bus0.running, bus0.lap_bcd, bus0.lap_valid,
                   bus0.lap_count, bus0.lap_full, bus0.overflow);
      compare_unit(1, bus1.time_bcd, bus1.running, bus1.lap_bcd, bus1.lap_valid,
                   bus1.lap_count, bus1.lap_full, bus1.overflow);
    end
  end

  task automatic step(input bit st, input bit sp, input bit lp, input bit cl, input bit rd);
    start_s = st; stop_s = sp; lap_s = lp; clear_s = cl; lap_rd_s = rd;
    @(posedge clock);
    @(negedge clock);
    start_s = 1'b0; stop_s = 1'b0; lap_s = 1'b0; clear_s = 1'b0; lap_rd_s = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0);
  endtask

  task automatic wait_count(input logic [W-1:0] target);
    int b;
    b = 0;
    while (bus0.time_bcd !== target && b < 2000) begin
      idle(1);
      b++;
    end
    if (b >= 2000) cmp("wait_count_timeout", bus0.time_bcd, target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    cmp("reset.time_bcd", bus0.time_bcd, 8'h00);
    cmp("reset.running", bus0.running, 1'b0);
    cmp("reset.lap_count", bus0.lap_count, 2'd0);
    reset_n = 1'b1;

    // Free run from start
    step(1, 0, 0, 0, 0);
    cmp("run.running_cycle1", bus0.running, 1'b1);
    idle(3);
    cmp("run.cycle3", bus0.time_bcd, 8'h00);
    idle(1);
    cmp("run.cycle4", bus0.time_bcd, 8'h01);
    idle(32);
    cmp("run.cycle36", bus0.time_bcd, 8'h09);
    idle(4);
    cmp("run.cycle40", bus0.time_bcd, 8'h10);

    // Pause keeps the fractional unit
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    idle(5);
    step(0, 1, 0, 0, 0);
    cmp("pause.running", bus0.running, 1'b0);
    idle(20);
    cmp("pause.hold", bus0.time_bcd, 8'h01);
    step(1, 0, 0, 0, 0);
    idle(1);
    cmp("resume.plus1", bus0.time_bcd, 8'h01);
    idle(1);
    cmp("resume.plus2", bus0.time_bcd, 8'h02);

    // Lap capture and drop on full
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    wait_count(8'h03);
    step(0, 0, 1, 0, 0);
    cmp("lap1.count", bus0.lap_count, 2'd1);
    cmp("lap1.head", bus0.lap_bcd, 8'h03);
    wait_count(8'h05);
    step(0, 0, 1, 0, 0);
    cmp("lap2.full", bus0.lap_full, 1'b1);
    wait_count(8'h07);
    step(0, 0, 1, 0, 0);
    cmp("lap3.dropped_count", bus0.lap_count, 2'd2);
    cmp("lap3.head", bus0.lap_bcd, 8'h03);
    step(0, 0, 0, 0, 1);
    cmp("pop1.head", bus0.lap_bcd, 8'h05);
    step(0, 0, 0, 0, 1);
    cmp("pop2.valid", bus0.lap_valid, 1'b0);
    cmp("pop2.head", bus0.lap_bcd, 8'h00);

    // Overflow: wrap vs saturate
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    wait_count(8'h99);
    idle(4);
    cmp("wrap.time_bcd", bus0.time_bcd, 8'h00);
    cmp("wrap.overflow", bus0.overflow, 1'b1);
    cmp("wrap.running", bus0.running, 1'b1);
    cmp("sat.time_bcd", bus1.time_bcd, 8'h99);
    cmp("sat.overflow", bus1.overflow, 1'b1);

    // Simultaneous events
    step(0, 0, 1, 0, 0);
    step(1, 0, 1, 1, 1);
    cmp("clear_all.time_bcd", bus0.time_bcd, 8'h00);
    cmp("clear_all.lap_count", bus0.lap_count, 2'd0);
    cmp("clear_all.overflow", bus0.overflow, 1'b0);
    cmp("clear_all.running", bus0.running, 1'b0);
    step(1, 1, 0, 0, 0);
    cmp("start_stop_idle.running", bus0.running, 1'b0);
    step(1, 0, 0, 0, 0);
    wait_count(8'h01);
    step(0, 0, 1, 0, 0);
    wait_count(8'h02);
    step(0, 0, 1, 0, 0);
    wait_count(8'h03);
    step(0, 0, 1, 0, 1);
    cmp("full_push_pop.count", bus0.lap_count, 2'd2);
    cmp("full_push_pop.head", bus0.lap_bcd, 8'h02);

    // Reset mid-run with laps stored
    reset_n = 1'b0;
    idle(1);
    cmp("midreset.time_bcd", bus0.time_bcd, 8'h00);
    cmp("midreset.running", bus0.running, 1'b0);
    cmp("midreset.lap_count", bus0.lap_count, 2'd0);
    cmp("midreset.lap_bcd", bus0.lap_bcd, 8'h00);
    reset_n = 1'b1;

    // Randomised traffic, high churn then long runs that reach overflow
    repeat (3000) begin
      reset_n = ($urandom_range(0, 255) != 0);
      step($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 63) == 0, $urandom_range(0, 2) == 0);
    end
    reset_n = 1'b1;
    repeat (3000) begin
      reset_n = ($urandom_range(0, 2047) != 0);
      step($urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 1499) == 0, $urandom_range(0, 3) == 0);
    end
    reset_n = 1'b1;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
